// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared FSM state type and id width helper for cdc_req_sched
package cdc_pkg;

  // Scheduler phases: waiting for a request, driving cdc_req, enforcing the low gap
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Width of a requester index; never below one bit
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with pointer advancing past each winner
module rr_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_REQ-1:0]  valid,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] index
);

  logic [ID_WIDTH-1:0] ptr;

  // First valid requester at or after ptr, wrapping; grant only when enabled
  always_comb begin
    logic found;
    int   cand;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[cand]) begin
        found = 1'b1;
        index = ID_WIDTH'(cand);
      end
    end
    if (enable && found) begin
      grant[index] = 1'b1;
    end
  end

  // Move the pointer just past the winner whenever a grant is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (index == ID_WIDTH'(NUM_REQ - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/cdc_req_sched.sv
// rtl/cdc_req_sched.sv - shares one cdc_sync req/sig channel among round-robin requesters
module cdc_req_sched
  import cdc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int REQ_HIGH   = 4,
  parameter int GAP        = 8,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdc_req,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_sig,
  output logic                          busy
);

  localparam int CNT_MAX = (REQ_HIGH > GAP) ? REQ_HIGH : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic                enable;
  logic                accept;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] win_idx;

  // Grants are only offered while idle and out of reset
  assign enable    = (state == ST_IDLE) && !rst;
  assign req_ready = grant;
  assign accept    = |grant;
  assign busy      = (state != ST_IDLE);

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .valid  (req_valid),
    .grant  (grant),
    .index  (win_idx)
  );

  // Next-state: idle until accept, hold cdc_req for REQ_HIGH, then stay low for GAP
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = ST_ASSERT;
      ST_ASSERT: if (cnt == CNT_W'(REQ_HIGH - 1)) state_n = ST_GAP;
      ST_GAP:    if (cnt == CNT_W'(GAP - 1)) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Duration counter restarts from zero on every state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_n != state) || (state_n == ST_IDLE)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // cdc_req registered from next state so it is glitch-free toward the synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdc_req <= 1'b0;
    end else begin
      cdc_req <= (state_n == ST_ASSERT);
    end
  end

  // Payload captured at acceptance and held until the next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdc_sig <= '0;
    end else if (accept) begin
      cdc_sig <= {win_idx, req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

endmodule

// File: tb/tb_cdc_req_sched.sv
// tb/tb_cdc_req_sched.sv - self-checking bench for cdc_req_sched
module tb_cdc_req_sched;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int RH     = 4;
  localparam int GP     = 8;
  localparam int PERIOD = RH + GP + 1;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          cdc_req;
  logic [9:0]    cdc_sig;
  logic          busy;

  int tests;
  int fails;

  int m_ptr;
  int m_free;
  int m_last;
  logic [9:0] m_sig;
  int cyc;
  int q_grants[$];
  int q_cycles[$];

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  r;
    logic        q;
    logic        b;
    logic [9:0]  s;
  } vec_t;

  vec_t tbl[14];

  cdc_req_sched #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .REQ_HIGH   (RH),
    .GAP        (GP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdc_req   (cdc_req),
    .cdc_sig   (cdc_sig),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_free = 0;
    m_last = -1000;
    m_sig  = '0;
    cyc    = 0;
    q_grants.delete();
    q_cycles.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle against the reference model; entered and left at posedge+1
  task automatic drive_check(input logic [3:0] v, input logic [31:0] d, output int w);
    logic [3:0] er;
    logic er_req, er_busy;
    int idx;
    req_valid = v;
    req_data  = d;
    er = '0;
    w  = -1;
    if (cyc >= m_free && v != 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && v[idx]) w = idx;
      end
      er[w] = 1'b1;
    end
    er_req  = (cyc >= m_last + 1) && (cyc <= m_last + RH);
    er_busy = (cyc >= m_last + 1) && (cyc <= m_last + RH + GP);
    @(negedge clk);
    chk("ready", 32'(req_ready), 32'(er));
    chk("cdc_req", 32'(cdc_req), 32'(er_req));
    chk("busy", 32'(busy), 32'(er_busy));
    chk("cdc_sig", 32'(cdc_sig), 32'(m_sig));
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) begin
        q_grants.push_back(k);
        q_cycles.push_back(cyc);
      end
    end
    if (w >= 0) begin
      m_last = cyc;
      m_free = cyc + PERIOD;
      m_ptr  = (w + 1) % N;
      m_sig  = {2'(w), d[w*DW +: DW]};
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int w;
    logic [3:0]  pend;
    logic [7:0]  lane[N];
    logic [31:0] dd;
    logic [31:0] rnd;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    model_reset();

    // Reset state with all requesters valid
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_cdc_req", 32'(cdc_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cdc_sig", 32'(cdc_sig), 32'h0);
    @(posedge clk); #1;

    // Single request on lane 2, then re-request across the gap boundary
    for (int i = 0; i < 14; i++) begin
      tbl[i].v = 4'b0000; tbl[i].d = 32'h0; tbl[i].r = 4'b0000;
      tbl[i].q = 1'b0;    tbl[i].b = 1'b1;  tbl[i].s = 10'h2A5;
      if (i >= 1 && i <= 4) tbl[i].q = 1'b1;
      if (i >= 5) begin tbl[i].v = 4'b0100; tbl[i].d = 32'h00A50000; end
    end
    tbl[0].v = 4'b0100; tbl[0].d = 32'h00A50000; tbl[0].r = 4'b0100;
    tbl[0].b = 1'b0;    tbl[0].s = 10'h000;
    tbl[13].r = 4'b0100; tbl[13].b = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].v;
      req_data  = tbl[i].d;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_cdc_req", i), 32'(cdc_req), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_cdc_sig", i), 32'(cdc_sig), 32'(tbl[i].s));
      @(posedge clk); #1;
    end

    // All four valid continuously: order 0,1,2,3,0 every PERIOD cycles
    do_reset();
    for (int c = 0; c < 4 * PERIOD + 1; c++) begin
      drive_check(4'b1111, $urandom, w);
    end
    chk("rr_count", 32'(q_grants.size()), 32'd5);
    if (q_grants.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_order%0d", k), 32'(q_grants[k]), 32'(k % N));
        chk($sformatf("rr_cycle%0d", k), 32'(q_cycles[k]), 32'(k * PERIOD));
      end
    end

    // Lane 3 held, lane 1 rises during the gap: 3, then 1, then 3
    do_reset();
    for (int c = 0; c < 2 * PERIOD + 1; c++) begin
      if (c >= 6 && c <= PERIOD) drive_check(4'b1010, 32'h3C001100, w);
      else                       drive_check(4'b1000, 32'h3C001100, w);
    end
    chk("hold_count", 32'(q_grants.size()), 32'd3);
    if (q_grants.size() >= 3) begin
      chk("hold_g0", 32'(q_grants[0]), 32'd3);
      chk("hold_g1", 32'(q_grants[1]), 32'd1);
      chk("hold_g2", 32'(q_grants[2]), 32'd3);
      chk("hold_c1", 32'(q_cycles[1]), 32'(PERIOD));
    end

    // Reset in the middle of ASSERT discards the transfer, pointer restarts at 0
    do_reset();
    drive_check(4'b0100, 32'h00770000, w);
    drive_check(4'b1111, 32'h44332211, w);
    req_valid = 4'b1111;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_cdc_req", 32'(cdc_req), 32'h0);
    chk("mid_rst_cdc_sig", 32'(cdc_sig), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive_check(4'b1111, 32'h44332211, w);
    chk("post_rst_grant", 32'(w), 32'd0);
    if (q_grants.size() >= 1) chk("post_rst_dut_grant", 32'(q_grants[0]), 32'd0);
    else chk("post_rst_dut_grant", 32'hFFFFFFFF, 32'd0);
    for (int c = 0; c < PERIOD; c++) drive_check(4'b1111, 32'h44332211, w);

    // Random traffic: requesters hold until accepted, occasionally withdraw
    do_reset();
    pend = '0;
    for (int i = 0; i < N; i++) lane[i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        rnd = $urandom;
        if (!pend[i] && rnd[1:0] == 2'b00) begin
          pend[i] = 1'b1;
          lane[i] = rnd[15:8];
        end else if (pend[i] && rnd[7:4] == 4'hF) begin
          pend[i] = 1'b0;
        end
      end
      dd = {lane[3], lane[2], lane[1], lane[0]};
      drive_check(pend, dd, w);
      if (w >= 0) pend[w] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
